// File: rtl/vga_pkg.sv
// Shared VGA timing constants, streamer state encoding and pixel-format helpers
// used by the timing generator and the pixel streamer.
package vga_pkg;

  localparam int VGA_DATA_WIDTH = 16;
  localparam int VGA_CNT_WIDTH  = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Keep the top four bits of each RGB565 channel.
  function automatic rgb444_t rgb565_to_444(input logic [15:0] px);
    rgb444_t c;
    c.r = px[15:12];
    c.g = px[10:7];
    c.b = px[4:1];
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running horizontal/vertical raster counters with active-area, raw
// active-low syncs, an end-of-frame strobe and the frame_start pulse.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int CNT_WIDTH = VGA_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  output logic active,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic frame_last,
  output logic frame_start
);

  localparam logic [CNT_WIDTH-1:0] H_ACT  = CNT_WIDTH'(H_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] H_SS   = CNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [CNT_WIDTH-1:0] H_SE   = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_WIDTH-1:0] H_END  = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_WIDTH-1:0] V_ACT  = CNT_WIDTH'(V_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] V_SS   = CNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [CNT_WIDTH-1:0] V_SE   = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_WIDTH-1:0] V_END  = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] h_cnt;
  logic [CNT_WIDTH-1:0] v_cnt;
  logic h_last;
  logic v_last;

  assign h_last     = (h_cnt == H_END);
  assign v_last     = (v_cnt == V_END);
  assign frame_last = h_last && v_last;
  assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_raw  = !((h_cnt >= H_SS) && (h_cnt < H_SE));
  assign vsync_raw  = !((v_cnt >= V_SS) && (v_cnt < V_SE));

  // frame_start is registered from the last raster position so it lines up
  // with h=0, v=0 while still resetting to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_last;
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) v_cnt <= '0;
        else        v_cnt <= v_cnt + ONE;
      end else begin
        h_cnt <= h_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/vga_pixel_streamer.sv
// Pops one RGB565 word per active pixel from the line FIFO and drives 4-4-4
// RGB, syncs and data-enable with a fixed 2-cycle latency from the raster.
module vga_pixel_streamer
  import vga_pkg::*;
#(
  parameter int          DATA_WIDTH    = VGA_DATA_WIDTH,
  parameter int          H_ACTIVE      = VGA_H_ACTIVE,
  parameter int          H_FP          = VGA_H_FP,
  parameter int          H_SYNC        = VGA_H_SYNC,
  parameter int          H_BP          = VGA_H_BP,
  parameter int          V_ACTIVE      = VGA_V_ACTIVE,
  parameter int          V_FP          = VGA_V_FP,
  parameter int          V_SYNC        = VGA_V_SYNC,
  parameter int          V_BP          = VGA_V_BP,
  parameter int          CNT_WIDTH     = VGA_CNT_WIDTH,
  parameter logic [11:0] UNDERFLOW_RGB = 12'h000
) (
  input  logic                  clk_read,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_half_full,
  output logic                  fifo_read_enable,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  vga_de,
  output logic                  frame_start,
  output logic                  underflow,
  output logic [15:0]           underflow_count,
  input  logic                  clear_underflow,
  output logic [1:0]            fsm_state
);

  logic    active;
  logic    hsync_raw;
  logic    vsync_raw;
  logic    frame_last;
  state_t  state;
  logic    run;
  logic    pop;
  logic    miss;
  logic    pop_s1;
  logic    miss_s1;
  logic    de_s1;
  logic    hsync_s1;
  logic    vsync_s1;
  rgb444_t pix;

  vga_timing_gen #(
    .H_ACTIVE  (H_ACTIVE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_ACTIVE  (V_ACTIVE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timing (
    .clk         (clk_read),
    .rst_n       (rst_n),
    .active      (active),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .frame_last  (frame_last),
    .frame_start (frame_start)
  );

  // FIFO pop handshake: fifo_read_enable is a request that the FIFO honours
  // whenever fifo_empty is low in the same cycle; the popped word appears on
  // fifo_read_data in the following cycle. Nothing is popped while empty.
  assign run              = (state == RUN);
  assign pop              = run && active && !fifo_empty;
  assign miss             = run && active && fifo_empty;
  assign fifo_read_enable = pop;
  assign fsm_state        = state;

  // Transitions are taken on the last raster position so the new state is
  // already in force at h=0, v=0, making (0,0) the first streamed pixel.
  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (enable && fifo_half_full) state <= ARMED;
        ARMED:   if (frame_last) state <= enable ? RUN : IDLE;
        RUN:     if (frame_last && !enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      pop_s1    <= 1'b0;
      miss_s1   <= 1'b0;
      de_s1     <= 1'b0;
      hsync_s1  <= 1'b1;
      vsync_s1  <= 1'b1;
      vga_de    <= 1'b0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      pix       <= '0;
    end else begin
      pop_s1    <= pop;
      miss_s1   <= miss;
      de_s1     <= run && active;
      hsync_s1  <= hsync_raw;
      vsync_s1  <= vsync_raw;
      vga_de    <= de_s1;
      vga_hsync <= hsync_s1;
      vga_vsync <= vsync_s1;
      if (pop_s1)       pix <= rgb565_to_444(fifo_read_data[15:0]);
      else if (miss_s1) pix <= rgb444_t'(UNDERFLOW_RGB);
      else              pix <= '0;
    end
  end

  assign vga_r = pix.r;
  assign vga_g = pix.g;
  assign vga_b = pix.b;

  // A clear in the same cycle as a counted miss drops that miss.
  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      underflow       <= 1'b0;
      underflow_count <= 16'd0;
    end else if (clear_underflow) begin
      underflow       <= 1'b0;
      underflow_count <= 16'd0;
    end else if (miss_s1) begin
      underflow <= 1'b1;
      if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_streamer.sv
// Directed bench for vga_pixel_streamer on a shrunken raster (25x10), with a
// raster/FSM reference model and a queue of expected pin values.
module tb_vga_pixel_streamer;
  import vga_pkg::*;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic [11:0] UNDER_RGB = 12'h5A3;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] fifo_read_data;
  logic        fifo_empty;
  logic        fifo_half_full;
  logic        fifo_read_enable;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_de;
  logic        frame_start;
  logic        underflow;
  logic [15:0] underflow_count;
  logic        clear_underflow;
  logic [1:0]  fsm_state;

  int          tests = 0;
  int          fails = 0;
  state_t      m_state;
  int          m_h, m_v;
  bit          m_wrapped;
  bit          chk_en;
  logic        fre_s;
  logic [15:0] fifo_q[$];
  logic [14:0] exp_q[$];
  int          hs_low, vs_low, de_cnt, pop_cnt;
  int          s_hs, s_vs, s_de, s_pop;
  int          guard;

  vga_pixel_streamer #(
    .DATA_WIDTH    (16),
    .H_ACTIVE      (HA),
    .H_FP          (HF),
    .H_SYNC        (HS),
    .H_BP          (HB),
    .V_ACTIVE      (VA),
    .V_FP          (VF),
    .V_SYNC        (VS),
    .V_BP          (VB),
    .CNT_WIDTH     (10),
    .UNDERFLOW_RGB (UNDER_RGB)
  ) dut (
    .clk_read         (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .fifo_read_data   (fifo_read_data),
    .fifo_empty       (fifo_empty),
    .fifo_half_full   (fifo_half_full),
    .fifo_read_enable (fifo_read_enable),
    .vga_r            (vga_r),
    .vga_g            (vga_g),
    .vga_b            (vga_b),
    .vga_hsync        (vga_hsync),
    .vga_vsync        (vga_vsync),
    .vga_de           (vga_de),
    .frame_start      (frame_start),
    .underflow        (underflow),
    .underflow_count  (underflow_count),
    .clear_underflow  (clear_underflow),
    .fsm_state        (fsm_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle model: compares stage-0 outputs now, queues the expected pin
  // values, which surface two cycles later, then advances raster and state.
  task automatic monitor();
    logic        m_act, m_run, e_pop, e_de, e_hs, e_vs, m_last;
    logic [15:0] w;
    logic [11:0] e_pix;
    logic [14:0] e;
    m_act = (m_h < HA) && (m_v < VA);
    m_run = (m_state == RUN);
    e_pop = m_run && m_act && !fifo_empty;
    e_de  = m_run && m_act;
    e_hs  = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
    e_vs  = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
    w     = fifo_q[0];
    if (e_pop)     e_pix = {w[15:12], w[10:7], w[4:1]};
    else if (e_de) e_pix = UNDER_RGB;
    else           e_pix = 12'h000;
    check("fifo_read_enable", fifo_read_enable, e_pop);
    check("frame_start", frame_start, (m_h == 0) && (m_v == 0) && m_wrapped);
    check("fsm_state", fsm_state, m_state);
    exp_q.push_back({e_de, e_hs, e_vs, e_pix});
    if (exp_q.size() > 2) begin
      e = exp_q.pop_front();
      check("pins", {vga_de, vga_hsync, vga_vsync, vga_r, vga_g, vga_b}, e);
    end
    if (!vga_hsync) hs_low++;
    if (!vga_vsync) vs_low++;
    if (vga_de) de_cnt++;
    if (fifo_read_enable) pop_cnt++;
    m_last = (m_h == HT - 1) && (m_v == VT - 1);
    case (m_state)
      IDLE:    if (enable && fifo_half_full) m_state = ARMED;
      ARMED:   if (m_last) m_state = enable ? RUN : IDLE;
      RUN:     if (m_last && !enable) m_state = IDLE;
      default: m_state = IDLE;
    endcase
    if (m_h == HT - 1) begin
      m_h = 0;
      if (m_v == VT - 1) begin
        m_v = 0;
        m_wrapped = 1'b1;
      end else begin
        m_v++;
      end
    end else begin
      m_h++;
    end
  endtask

  // One clock: check at the falling edge, then service the FIFO model just
  // after the rising edge so the popped word is valid for the next cycle.
  task automatic tick();
    @(negedge clk);
    if (chk_en) monitor();
    fre_s = fifo_read_enable;
    @(posedge clk);
    #1;
    if (fre_s) begin
      fifo_read_data = fifo_q.pop_front();
      fifo_q.push_back(16'($urandom_range(0, 65535)));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; fifo_empty = 1'b0; fifo_half_full = 1'b0;
    clear_underflow = 1'b0; fifo_read_data = 16'h0000;
    chk_en = 1'b0; fre_s = 1'b0;
    m_h = 0; m_v = 0; m_state = IDLE; m_wrapped = 1'b0;
    hs_low = 0; vs_low = 0; de_cnt = 0; pop_cnt = 0;
    fifo_q.push_back(16'hF800);
    for (int i = 1; i < 1024; i++) fifo_q.push_back(16'($urandom_range(0, 65535)));

    ticks(3);
    check("rst_hsync", vga_hsync, 1'b1);
    check("rst_vsync", vga_vsync, 1'b1);
    check("rst_de", vga_de, 1'b0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    check("rst_fifo_read_enable", fifo_read_enable, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_underflow", underflow, 1'b0);
    check("rst_underflow_count", underflow_count, 16'd0);
    check("rst_state", fsm_state, IDLE);

    // Two frames with streaming disabled.
    rst_n = 1'b1;
    chk_en = 1'b1;
    ticks(3);
    s_hs = hs_low; s_vs = vs_low; s_de = de_cnt; s_pop = pop_cnt;
    ticks(2 * HT * VT);
    check("hsync_low_cycles", hs_low - s_hs, 2 * HS * VT);
    check("vsync_low_cycles", vs_low - s_vs, 2 * VS * HT);
    check("de_while_disabled", de_cnt - s_de, 0);
    check("pops_while_disabled", pop_cnt - s_pop, 0);

    // Enable with a primed FIFO; streaming starts at the next frame origin.
    enable = 1'b1;
    fifo_half_full = 1'b1;
    guard = 0;
    while (!(m_state == RUN && m_h == 0 && m_v == 0) && guard < 3 * HT * VT) begin
      tick();
      guard++;
    end
    check("run_reached", guard < 3 * HT * VT, 1'b1);
    check("first_pop_at_origin", fifo_read_enable, 1'b1);
    s_pop = pop_cnt;
    ticks(2);
    check("first_pixel_rgb", {vga_r, vga_g, vga_b}, 12'hF00);
    check("first_pixel_de", vga_de, 1'b1);
    ticks(HT - 2);
    check("pops_per_line", pop_cnt - s_pop, HA);
    ticks(HT * VT - HT);
    check("pops_per_frame", pop_cnt - s_pop, HA * VA);
    check("no_underflow_full_frame", underflow, 1'b0);

    // Five missed pixels mid-line, then a clear.
    ticks(5);
    fifo_empty = 1'b1;
    ticks(5);
    fifo_empty = 1'b0;
    ticks(4);
    check("underflow_set", underflow, 1'b1);
    check("underflow_count_5", underflow_count, 16'd5);
    clear_underflow = 1'b1;
    ticks(1);
    clear_underflow = 1'b0;
    ticks(1);
    check("underflow_cleared", underflow, 1'b0);
    check("underflow_count_cleared", underflow_count, 16'd0);

    // Clear coinciding with a counted miss wins; the next miss counts as 1.
    ticks(HT - 16 + 2);
    fifo_empty = 1'b1;
    ticks(1);
    fifo_empty = 1'b0;
    clear_underflow = 1'b1;
    ticks(1);
    clear_underflow = 1'b0;
    ticks(2);
    check("clear_beats_miss_flag", underflow, 1'b0);
    check("clear_beats_miss_count", underflow_count, 16'd0);
    fifo_empty = 1'b1;
    ticks(1);
    fifo_empty = 1'b0;
    ticks(3);
    check("miss_after_clear_flag", underflow, 1'b1);
    check("miss_after_clear_count", underflow_count, 16'd1);

    // Drop enable at the start of line 2: the frame still completes.
    guard = 0;
    while (!(m_h == 0 && m_v == 2) && guard < HT * VT) begin
      tick();
      guard++;
    end
    check("line2_reached", guard < HT * VT, 1'b1);
    enable = 1'b0;
    s_pop = pop_cnt;
    guard = 0;
    while (!(m_h == 0 && m_v == 0) && guard < HT * VT) begin
      tick();
      guard++;
    end
    check("frame_end_reached", guard < HT * VT, 1'b1);
    check("pops_after_disable", pop_cnt - s_pop, (VA - 2) * HA);
    check("idle_at_frame_start", fsm_state, IDLE);
    s_pop = pop_cnt;
    s_de = de_cnt;
    ticks(HT * VT);
    check("no_pops_when_idle", pop_cnt - s_pop, 0);
    check("no_de_when_idle", de_cnt - s_de, 0);

    // Restart, then assert reset asynchronously in the middle of a line.
    enable = 1'b1;
    guard = 0;
    while (!(m_state == RUN && m_h == 5 && m_v == 1) && guard < 3 * HT * VT) begin
      tick();
      guard++;
    end
    check("rerun_reached", guard < 3 * HT * VT, 1'b1);
    check("streaming_before_reset", vga_de, 1'b1);
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hsync", vga_hsync, 1'b1);
    check("async_rst_vsync", vga_vsync, 1'b1);
    check("async_rst_de", vga_de, 1'b0);
    check("async_rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    check("async_rst_fifo_read_enable", fifo_read_enable, 1'b0);
    check("async_rst_underflow", underflow, 1'b0);
    check("async_rst_underflow_count", underflow_count, 16'd0);
    check("async_rst_state", fsm_state, IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_pixel_streamer.md
Name: vga_pixel_streamer

Overview:
- Sits in the VGA (25 MHz) domain, directly downstream of the SDRAM-to-VGA line FIFO.
- Generates 640x480@60 timing and pops one RGB565 word per active pixel from the FIFO.
- Drives 4-4-4 RGB, sync and data-enable to the DAC/pins.
- Handles FIFO priming, the registered FIFO read latency, and underflow detection/reporting.

Parameters:
DATA_WIDTH, 16, FIFO word width (RGB565)
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
CNT_WIDTH, 10, h/v counter width
UNDERFLOW_RGB, 12'h000, colour output for a missed pixel

Ports:
clk_read  in  1  VGA pixel clock (FIFO read clock)
rst_n  in  1  reset
enable  in  1  start/continue streaming
fifo_read_data  in  DATA_WIDTH  FIFO output, valid the cycle after a pop
fifo_empty  in  1  FIFO empty
fifo_half_full  in  1  FIFO at least half full
fifo_read_enable  out  1  pop request
vga_r / vga_g / vga_b  out  4 each  colour
vga_hsync  out  1  active-low hsync
vga_vsync  out  1  active-low vsync
vga_de  out  1  active-video qualifier
frame_start  out  1  one-cycle pulse at h=0, v=0 (stage 0)
underflow  out  1  sticky underflow flag
underflow_count  out  16  saturating missed-pixel count
clear_underflow  in  1  synchronous clear of underflow and underflow_count

Behaviour:
- Clock is clk_read.
- Reset is rst_n: asynchronous, active-low.
- Reset values: counters 0, state IDLE, fifo_read_enable 0, RGB 0, vga_de 0, vga_hsync 1, vga_vsync 1, frame_start 0, underflow 0, underflow_count 0.

Timing counters:
- h_cnt 0..H_TOTAL-1 (H_TOTAL = 800), v_cnt 0..V_TOTAL-1 (525).
- v_cnt increments when h_cnt wraps; both wrap to 0.
- Counters run in every state.
- active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
- hsync asserted (0) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v_cnt.

State machine:
- IDLE: waits for enable && fifo_half_full, then -> ARMED.
- ARMED: waits for frame_start, then -> RUN. The first popped pixel is (0,0).
- RUN: streams pixels.
- enable low in any state: -> IDLE at the next frame_start. The current frame completes.
- In IDLE/ARMED: fifo_read_enable = 0, vga_de = 0, RGB = 0; syncs keep toggling.

Pipeline (stage 0 = counters):
- Stage 0: fifo_read_enable = (state==RUN) && active && !fifo_empty. Registered alongside "popped" and "miss" (RUN && active && fifo_empty).
- Stage 1: fifo_read_data is valid for popped.
- Stage 2: output registers.
  - Pixel: r=data[15:12], g=data[10:7], b=data[4:1].
  - miss: UNDERFLOW_RGB.
  - Inactive: 0.
- hsync, vsync and de are delayed 2 cycles, so every pin output has 2-cycle latency from the counter position.

Underflow:
- Each miss cycle sets underflow and increments underflow_count; the count saturates at 0xFFFF.
- Missed pixels are skipped, not retried. Later pixels shift by the miss count; recovery is by software re-enable.
- clear_underflow and a miss in the same cycle: clear wins, then the count becomes 1 on the next miss.
- frame_start is not delayed and is for upstream (SDRAM fetcher) use.
- Reset mid-frame: all outputs return to reset values immediately; the FIFO is not drained by this block.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants and derived H_TOTAL/V_TOTAL;
  - a state enum typedef (IDLE, ARMED, RUN);
  - an rgb444 struct typedef;
  - an rgb565-to-444 function.
- Sub-module vga_timing_gen holds the h/v counters, active, raw syncs and frame_start.
- vga_pixel_streamer instantiates vga_timing_gen and adds the FSM, pop logic, pipeline and underflow logic.

Test Plan:
- Reset then 2 frames with enable=0 -> hsync low 96 cycles per 800-cycle line, vsync low 2 lines per 525, de never 1, fifo_read_enable never 1.
- enable=1 with FIFO model holding 1024 words, half_full=1 -> RUN from the next frame_start; first pop at h=0, v=0; pixel 0xF800 appears as r=F, g=0, b=0 exactly 2 cycles later with de=1; exactly 640 pops per active line.
- Full frame from an always-non-empty FIFO -> 307200 pops per frame, 0 pops in blanking, underflow stays 0.
- Force fifo_empty=1 for 5 active cycles mid-line -> 5 cycles of UNDERFLOW_RGB with de=1, underflow=1, underflow_count=5; pulse clear_underflow -> both 0.
- Drop enable mid-frame -> the frame completes streaming, state goes to IDLE at the next frame_start, no further pops.
- Assert rst_n=0 asynchronously mid-line -> hsync/vsync=1, outputs 0, fifo_read_enable=0 in the same cycle, without waiting for a clock edge.
